// File: rtl/pwm_pkg.sv
// Constants and types shared by the PWM link transmitter and receiver.
// The transmitter divides each period into PWM_SLOTS slots and encodes speed as the number of high slots.
package pwm_pkg;

  localparam int PWM_SLOTS = 16;
  localparam int SPEED_W   = 4;

  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(PWM_SLOTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_STUCK
  } pwm_dec_state_t;

endpackage

// File: rtl/pwm_decoder_if.sv
// Signal bundle between the PWM line source and the decoder with its telemetry outputs.
// The master side drives the line; the slave side decodes it.
interface pwm_decoder_if;
  import pwm_pkg::*;

  logic               pwm_in;
  logic [SPEED_W-1:0] speed_out;
  logic               speed_valid;
  logic               period_err;
  logic               stuck_high;

  modport master (
    output pwm_in,
    input  speed_out,
    input  speed_valid,
    input  period_err,
    input  stuck_high
  );

  modport slave (
    input  pwm_in,
    output speed_out,
    output speed_valid,
    output period_err,
    output stuck_high
  );

endinterface

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM line into the FPGA_clk domain and detects its edges.
// rise/fall are single-cycle pulses; high and low widths pass through unchanged.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic FPGA_clk,
  input  logic FPGA_reset_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
    if (!FPGA_reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// Receive side of the 16-level motor PWM link: measures high time and period of the synchronized
// line, recovers the speed code at every rise, and flags off-nominal or stuck signals.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 12,
  parameter int SYNC_STAGES     = 2,
  parameter int PERIOD_TOL_LOG2 = PRESCALER_WIDTH - 2
) (
  input  logic          FPGA_clk,
  input  logic          FPGA_reset_n,
  pwm_decoder_if.slave  bus
);

  localparam int CNT_W  = PRESCALER_WIDTH + 5;
  localparam int CNT_W1 = CNT_W + 1;

  localparam logic [CNT_W-1:0] TIMEOUT    = '1;
  localparam logic [CNT_W-1:0] NOMINAL    = CNT_W'(PWM_SLOTS) << PRESCALER_WIDTH;
  localparam logic [CNT_W-1:0] PER_TOL    = CNT_W'(1) << PERIOD_TOL_LOG2;
  localparam logic [CNT_W:0]   ROUND_HALF = CNT_W1'(1) << (PRESCALER_WIDTH - 1);

  logic level, rise, fall;

  pwm_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .FPGA_clk     (FPGA_clk),
    .FPGA_reset_n (FPGA_reset_n),
    .pwm_in       (bus.pwm_in),
    .level        (level),
    .rise         (rise),
    .fall         (fall)
  );

  pwm_dec_state_t     state_q, state_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               stuck_q, stuck_d;

  // Counters stop at TIMEOUT instead of wrapping, so a dead line can never look like a valid period.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == TIMEOUT) ? v : v + CNT_W'(1);
  endfunction

  // Publish arithmetic: round high time to the nearest slot, clamp to the top code.
  logic [CNT_W:0]     hi_round;
  logic [SPEED_W-1:0] speed_pub;
  logic [CNT_W-1:0]   per_diff;
  logic               err_pub;

  assign hi_round  = ({1'b0, hi_q} + ROUND_HALF) >> PRESCALER_WIDTH;
  assign speed_pub = (hi_round > CNT_W1'(SPEED_MAX)) ? SPEED_MAX : hi_round[SPEED_W-1:0];
  assign per_diff  = (per_q >= NOMINAL) ? (per_q - NOMINAL) : (NOMINAL - per_q);
  assign err_pub   = (per_diff > PER_TOL);

  always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
    if (!FPGA_reset_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      per_q   <= '0;
      speed_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      speed_q <= speed_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      stuck_q <= stuck_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    per_d   = per_q;
    speed_d = speed_q;
    valid_d = 1'b0;
    err_d   = err_q;
    stuck_d = stuck_q;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hi_d    = CNT_W'(1);
          per_d   = CNT_W'(1);
        end
      end

      S_HIGH: begin
        // An edge takes priority over a coincident timeout.
        if (fall) begin
          state_d = S_LOW;
          per_d   = sat_inc(per_q);
        end else if (per_q == TIMEOUT && level) begin
          state_d = S_STUCK;
          stuck_d = 1'b1;
          speed_d = SPEED_MAX;
          valid_d = 1'b1;
        end else begin
          hi_d    = sat_inc(hi_q);
          per_d   = sat_inc(per_q);
        end
      end

      S_LOW: begin
        if (rise) begin
          speed_d = speed_pub;
          err_d   = err_pub;
          valid_d = 1'b1;
          state_d = S_HIGH;
          hi_d    = CNT_W'(1);
          per_d   = CNT_W'(1);
        end else if (per_q == TIMEOUT) begin
          // A line parked low is the legal encoding of speed 0, not a period fault.
          state_d = S_IDLE;
          speed_d = '0;
          err_d   = 1'b0;
          valid_d = 1'b1;
        end else begin
          per_d   = sat_inc(per_q);
        end
      end

      S_STUCK: begin
        per_d = sat_inc(per_q);
        if (fall) begin
          state_d = S_LOW;
          stuck_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.speed_out   = speed_q;
  assign bus.speed_valid = valid_q;
  assign bus.period_err  = err_q;
  assign bus.stuck_high  = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder at PRESCALER_WIDTH=2 (slot 4 clk, nominal period 64, tol 1, timeout 127).
// Every publication is captured by a monitor and compared against hand-computed codes.
module tb_pwm_decoder;
  import pwm_pkg::*;

  localparam int PW = 2;

  logic FPGA_clk     = 1'b0;
  logic FPGA_reset_n = 1'b0;

  pwm_decoder_if bus ();

  pwm_decoder #(
    .PRESCALER_WIDTH (PW),
    .SYNC_STAGES     (2),
    .PERIOD_TOL_LOG2 (PW - 2)
  ) dut (
    .FPGA_clk     (FPGA_clk),
    .FPGA_reset_n (FPGA_reset_n),
    .bus          (bus)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int pub_speed[$];
  int pub_err[$];
  int pub_cyc[$];

  always @(posedge FPGA_clk) cyc++;

  always @(negedge FPGA_clk) begin
    if (bus.speed_valid === 1'b1) begin
      pub_speed.push_back(int'(bus.speed_out));
      pub_err.push_back(int'(bus.period_err));
      pub_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FPGA_clk);
  endtask

  task automatic clear_pubs();
    pub_speed.delete();
    pub_err.delete();
    pub_cyc.delete();
  endtask

  task automatic do_reset();
    FPGA_reset_n = 1'b0;
    bus.pwm_in   = 1'b0;
    tick(3);
    FPGA_reset_n = 1'b1;
    tick(2);
    clear_pubs();
  endtask

  // One PWM period starting with a rise: hi clocks high, then per-hi clocks low.
  task automatic pwm_period(input int hi, input int per);
    bus.pwm_in = 1'b1;
    tick(hi);
    bus.pwm_in = 1'b0;
    tick(per - hi);
  endtask

  // Rise that closes the previous period, then wait for its publication to land.
  task automatic closing_rise();
    bus.pwm_in = 1'b1;
    tick(6);
  endtask

  task automatic expect_pub(input string tag, input int idx, input int spd, input int err);
    check({tag, "_speed"}, pub_speed.size() > idx ? pub_speed[idx] : -1, spd);
    check({tag, "_err"},   pub_err.size()   > idx ? pub_err[idx]   : -1, err);
  endtask

  // Boundary table: rounding edges, clamp at 15, period tolerance edges.
  int t5_hi  [9] = '{22, 20, 20, 20, 20, 62, 6, 5, 1};
  int t5_per [9] = '{70, 65, 66, 63, 64, 64, 64, 64, 64};
  int t5_spd [9] = '{ 6,  5,  5,  5,  5, 15, 2, 1, 0};
  int t5_err [9] = '{ 1,  0,  1,  0,  0,  0, 0, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.pwm_in = 1'b0;

    // Reset state
    tick(2);
    check("rst_speed", bus.speed_out, 0);
    check("rst_valid", bus.speed_valid, 0);
    check("rst_err",   bus.period_err, 0);
    check("rst_stuck", bus.stuck_high, 0);
    check("rst_state", dut.state_q, S_IDLE);
    FPGA_reset_n = 1'b1;
    tick(2);

    // 1: steady speed 5 (20 high of 64)
    do_reset();
    repeat (4) pwm_period(20, 64);
    closing_rise();
    check("t1_count", pub_speed.size(), 4);
    for (int i = 0; i < 4; i++) expect_pub($sformatf("t1_pub%0d", i), i, 5, 0);
    for (int i = 1; i < pub_cyc.size(); i++)
      check($sformatf("t1_spacing%0d", i), pub_cyc[i] - pub_cyc[i-1], 64);
    check("t1_stuck", bus.stuck_high, 0);

    // 2: sweep speeds 1..15 at nominal period
    do_reset();
    for (int s = 1; s <= 15; s++) pwm_period(4 * s, 64);
    closing_rise();
    check("t2_count", pub_speed.size(), 15);
    for (int s = 1; s <= 15; s++) expect_pub($sformatf("t2_s%0d", s), s - 1, s, 0);
    check("t2_stuck", bus.stuck_high, 0);

    // 3: line goes quiet low after one period -> single speed-0 publication
    do_reset();
    pwm_period(20, 64);
    tick(200);
    check("t3_count", pub_speed.size(), 1);
    expect_pub("t3_pub", 0, 0, 0);
    check("t3_state", dut.state_q, S_IDLE);
    tick(200);
    check("t3_no_more", pub_speed.size(), 1);

    // 4: line held high
    do_reset();
    bus.pwm_in = 1'b1;
    tick(100);
    check("t4_early_stuck", bus.stuck_high, 0);
    check("t4_early_count", pub_speed.size(), 0);
    tick(100);
    check("t4_stuck", bus.stuck_high, 1);
    check("t4_speed", bus.speed_out, 15);
    check("t4_count", pub_speed.size(), 1);
    expect_pub("t4_pub", 0, 15, 0);
    bus.pwm_in = 1'b0;
    tick(6);
    check("t4_cleared", bus.stuck_high, 0);

    // 5: hand-driven boundary periods
    do_reset();
    pwm_period(t5_hi[0], t5_per[0]);
    bus.pwm_in = 1'b1;
    tick(10);
    check("t5_err_held", bus.period_err, 1);
    check("t5_speed_live", bus.speed_out, 6);
    tick(t5_hi[1] - 10);
    bus.pwm_in = 1'b0;
    tick(t5_per[1] - t5_hi[1]);
    for (int i = 2; i < 9; i++) pwm_period(t5_hi[i], t5_per[i]);
    closing_rise();
    check("t5_count", pub_speed.size(), 9);
    for (int i = 0; i < 9; i++) expect_pub($sformatf("t5_v%0d", i), i, t5_spd[i], t5_err[i]);

    // 6: asynchronous reset in mid-high
    do_reset();
    pwm_period(20, 64);
    pwm_period(24, 70);
    bus.pwm_in = 1'b1;
    tick(10);
    check("t6_pre_speed", bus.speed_out, 6);
    check("t6_pre_err",   bus.period_err, 1);
    #2 FPGA_reset_n = 1'b0;
    #1;
    check("t6_async_speed", bus.speed_out, 0);
    check("t6_async_err",   bus.period_err, 0);
    check("t6_async_valid", bus.speed_valid, 0);
    check("t6_async_state", dut.state_q, S_IDLE);
    bus.pwm_in = 1'b0;
    tick(3);
    #2 FPGA_reset_n = 1'b1;
    clear_pubs();
    tick(20);
    check("t6_quiet", pub_speed.size(), 0);
    pwm_period(20, 64);
    check("t6_first_period", pub_speed.size(), 0);
    closing_rise();
    check("t6_count", pub_speed.size(), 1);
    expect_pub("t6_pub", 0, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
